// File: rtl/cpu_prog_loader_if.sv
// Pin-level load port of the 8-bit CPU.
// The loader (master) drives load/addr/data/strobe; the CPU (slave) returns ack.
interface cpu_prog_loader_if;
    logic       bus_load;
    logic [3:0] bus_addr;
    logic [7:0] bus_data;
    logic       bus_stb;
    logic       bus_ack;

    modport master (
        output bus_load,
        output bus_addr,
        output bus_data,
        output bus_stb,
        input  bus_ack
    );

    modport slave (
        input  bus_load,
        input  bus_addr,
        input  bus_data,
        input  bus_stb,
        output bus_ack
    );
endinterface

// File: rtl/cpu_prog_loader.sv
// Host-side program loader: buffers bytes in a FIFO and writes them into CPU memory over the
// 4-phase strobe/ack load port at an auto-incrementing address, aborting on a stalled phase.
module cpu_prog_loader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    input  logic              start,
    input  logic [3:0]        start_addr,
    input  logic [4:0]        len,
    output logic              busy,
    output logic              done,
    output logic              err,
    cpu_prog_loader_if.master bus
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitData,
        StSetup,
        StStbHi,
        StStbLo,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic [3:0]      addr_q, addr_d;
    logic [4:0]      remain_q, remain_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            load_q, load_d;
    logic            stb_q, stb_d;
    logic [3:0]      bus_addr_q, bus_addr_d;
    logic [7:0]      bus_data_q, bus_data_d;
    logic            push, pop, flush, tmo_hit;

    assign wr_ready = (count_q != (PtrW+1)'(FIFO_DEPTH));
    assign push     = wr_valid && wr_ready;
    assign tmo_hit  = (tmo_q == TmoW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        pop      = 1'b0;
        flush    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (len != 5'd0 && len <= 5'd16) begin
                        addr_d   = start_addr;
                        remain_d = len;
                        err_d    = 1'b0;
                        state_d  = StWaitData;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StWaitData: begin
                if (count_q != '0) begin
                    state_d = StSetup;
                end
            end
            StSetup: begin
                tmo_d   = '0;
                state_d = StStbHi;
            end
            StStbHi: begin
                // An ack arriving in the last allowed cycle still completes the phase.
                if (bus.bus_ack) begin
                    pop      = 1'b1;
                    addr_d   = addr_q + 4'd1;
                    remain_d = remain_q - 5'd1;
                    tmo_d    = '0;
                    state_d  = StStbLo;
                end else if (tmo_hit) begin
                    flush   = 1'b1;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StStbLo: begin
                if (!bus.bus_ack) begin
                    state_d = (remain_q == 5'd0) ? StDone : StWaitData;
                end else if (tmo_hit) begin
                    flush   = 1'b1;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PtrW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PtrW+1)'(1);
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        busy_d     = (state_d == StWaitData) || (state_d == StSetup) ||
                     (state_d == StStbHi) || (state_d == StStbLo);
        load_d     = busy_d;
        stb_d      = (state_d == StStbHi);
        done_d     = (state_d == StDone);
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        if (state_d == StSetup) begin
            bus_addr_d = addr_q;
            bus_data_d = mem_q[rd_ptr_q];
        end else if (!busy_d) begin
            bus_addr_d = 4'd0;
            bus_data_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= 4'd0;
            remain_q   <= 5'd0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            load_q     <= 1'b0;
            stb_q      <= 1'b0;
            bus_addr_q <= 4'd0;
            bus_data_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            load_q     <= load_d;
            stb_q      <= stb_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign bus.bus_load = load_q;
    assign bus.bus_stb  = stb_q;
    assign bus.bus_addr = bus_addr_q;
    assign bus.bus_data = bus_data_q;
endmodule

// File: tb/tb_cpu_prog_loader.sv
// Directed bench for cpu_prog_loader: a CPU-side responder acks with one cycle of latency,
// a monitor records every strobe, and hand-computed writes and flags are compared.
module tb_cpu_prog_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] len;
    logic       busy;
    logic       done;
    logic       err;

    logic       ack_en = 1'b0;
    logic       stb_prev = 1'b0;
    logic       stb_last = 1'b0;
    int         tests_run = 0;
    int         tests_failed = 0;
    int         done_cnt = 0;
    int         stb_hi_cnt = 0;
    logic [11:0] wr_q[$];
    logic [11:0] exp_q[$];

    cpu_prog_loader_if bus_if ();

    cpu_prog_loader #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    // CPU responder: ack mirrors the strobe seen one cycle earlier.
    initial begin
        bus_if.bus_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus_if.bus_ack = ack_en && stb_prev;
            stb_prev = bus_if.bus_stb;
        end
    end

    always @(negedge clk) begin
        if (bus_if.bus_stb && !stb_last) wr_q.push_back({bus_if.bus_addr, bus_if.bus_data});
        if (bus_if.bus_stb) stb_hi_cnt++;
        if (done) done_cnt++;
        stb_last = bus_if.bus_stb;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] outs();
        return {wr_ready, busy, done, err, bus_if.bus_load, bus_if.bus_stb,
                bus_if.bus_addr, bus_if.bus_data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_valid = 1'b0;
        start = 1'b0;
        step();
        step();
        rst = 1'b0;
        wr_q.delete();
        exp_q.delete();
        done_cnt = 0;
        stb_hi_cnt = 0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        while (!wr_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("push_ready_bound", 32'(0), 32'(1));
        wr_valid = 1'b1;
        wr_data = b;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic start_xfer(input logic [3:0] a, input logic [4:0] l);
        start = 1'b1;
        start_addr = a;
        len = l;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) check(tag, 32'(0), 32'(1));
        step();
        step();
    endtask

    task automatic wait_stb(input string tag, input bit need_ack);
        int n = 0;
        @(negedge clk);
        while (!(bus_if.bus_stb && (!need_ack || bus_if.bus_ack)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check(tag, 32'(0), 32'(1));
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < wr_q.size()) check($sformatf("%s_wr%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_valid = 1'b0;
        wr_data = 8'h00;
        start = 1'b0;
        start_addr = 4'd0;
        len = 5'd0;

        // Reset state
        do_reset();
        check("reset_outputs", 32'(outs()), 32'(18'h20000));

        // Basic load
        ack_en = 1'b1;
        push_byte(8'h3A);
        push_byte(8'h5C);
        push_byte(8'h01);
        start_xfer(4'd2, 5'd3);
        check("basic_busy_load", 32'({busy, bus_if.bus_load, bus_if.bus_stb}), 32'(3'b110));
        step();
        check("basic_setup", 32'({bus_if.bus_stb, bus_if.bus_addr, bus_if.bus_data}),
              32'({1'b0, 4'd2, 8'h3A}));
        step();
        check("basic_stb_hi", 32'({bus_if.bus_stb, bus_if.bus_addr, bus_if.bus_data}),
              32'({1'b1, 4'd2, 8'h3A}));
        wait_idle("basic_idle_bound");
        exp_q = '{12'h23A, 12'h35C, 12'h401};
        check_writes("basic");
        check("basic_done_cnt", 32'(done_cnt), 32'(1));
        check("basic_flags", 32'(outs()), 32'(18'h20000));

        // Wrap and starvation
        do_reset();
        start_xfer(4'd14, 5'd4);
        for (int i = 0; i < 4; i++) begin
            repeat (10) step();
            check($sformatf("wrap_stall%0d", i),
                  32'({busy, bus_if.bus_load, bus_if.bus_stb, err}), 32'(4'b1100));
            push_byte(8'hA0 + 8'(i));
        end
        wait_idle("wrap_idle_bound");
        exp_q = '{12'hEA0, 12'hFA1, 12'h0A2, 12'h1A3};
        check_writes("wrap");
        check("wrap_done_err", 32'({done_cnt[3:0], err}), 32'({4'd1, 1'b0}));

        // Timeout with a silent responder
        do_reset();
        ack_en = 1'b0;
        push_byte(8'h77);
        push_byte(8'h88);
        start_xfer(4'd5, 5'd2);
        wait_idle("tmo_idle_bound");
        check("tmo_stb_cycles", 32'(stb_hi_cnt), 32'(8));
        check("tmo_flags", 32'({busy, bus_if.bus_load, bus_if.bus_stb, err}), 32'(4'b0001));
        check("tmo_no_done", 32'(done_cnt), 32'(0));
        exp_q = '{12'h577};
        check_writes("tmo");
        ack_en = 1'b1;
        wr_q.delete();
        start_xfer(4'd9, 5'd1);
        check("tmo_err_cleared", 32'({busy, err}), 32'(2'b10));
        repeat (5) step();
        check("tmo_fifo_flushed", 32'(wr_q.size()), 32'(0));
        push_byte(8'h42);
        wait_idle("tmo_retry_bound");
        exp_q = '{12'h942};
        check_writes("tmo_retry");
        check("tmo_retry_done", 32'(done_cnt), 32'(1));

        // Invalid lengths
        do_reset();
        start_xfer(4'd3, 5'd0);
        check("len0_flags", 32'({busy, bus_if.bus_load, err}), 32'(3'b001));
        repeat (3) step();
        check("len0_quiet", 32'({busy, bus_if.bus_load, wr_q.size() != 0}), 32'(3'b000));
        do_reset();
        start_xfer(4'd3, 5'd17);
        check("len17_flags", 32'({busy, bus_if.bus_load, err}), 32'(3'b001));
        repeat (3) step();
        check("len17_quiet", 32'({busy, bus_if.bus_load, wr_q.size() != 0}), 32'(3'b000));

        // Backpressure
        do_reset();
        ack_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data = 8'hB0 + 8'(i);
            check($sformatf("bp_ready%0d", i), 32'(wr_ready), 32'(1));
            step();
        end
        check("bp_full", 32'(wr_ready), 32'(0));
        wr_data = 8'hB4;
        repeat (3) step();
        check("bp_still_full", 32'(wr_ready), 32'(0));
        start_xfer(4'd0, 5'd5);
        begin
            int n = 0;
            while (!wr_ready && n < 50) begin
                step();
                n++;
            end
            if (n >= 50) check("bp_ready_bound", 32'(0), 32'(1));
        end
        check("bp_ready_after_pop", 32'({bus_if.bus_stb, bus_if.bus_load, 4'(wr_q.size())}),
              32'({1'b0, 1'b1, 4'd1}));
        step();
        wr_valid = 1'b0;
        wait_idle("bp_idle_bound");
        exp_q = '{12'h0B0, 12'h1B1, 12'h2B2, 12'h3B3, 12'h4B4};
        check_writes("bp");
        check("bp_done", 32'(done_cnt), 32'(1));

        // Push and pop on the same edge
        do_reset();
        push_byte(8'hC0);
        start_xfer(4'd7, 5'd2);
        wait_stb("sim_pop_bound", 1'b1);
        wr_valid = 1'b1;
        wr_data = 8'hC1;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wait_idle("sim_idle_bound");
        exp_q = '{12'h7C0, 12'h8C1};
        check_writes("sim");
        check("sim_done", 32'(done_cnt), 32'(1));

        // Reset during STB_HI
        do_reset();
        ack_en = 1'b0;
        push_byte(8'hD0);
        start_xfer(4'd1, 5'd1);
        wait_stb("rst_stb_bound", 1'b0);
        check("rst_pre_stb", 32'({bus_if.bus_stb, bus_if.bus_load}), 32'(2'b11));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_outputs", 32'(outs()), 32'(18'h20000));
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/cpu_prog_loader.md
# cpu_prog_loader

Host-side program loader that writes a program image into the 8-bit CPU's 16-byte memory over the CPU's pin-level load interface. Bytes are buffered in a small FIFO and each one is sent with a 4-phase strobe/ack handshake at an auto-incrementing address. A per-phase timeout aborts the transfer if the CPU stops responding. The block is the transmitting end of the CPU's load port and sits in front of the CPU in both the FPGA harness and the test bench.

## Interface
- `FIFO_DEPTH`, 4: byte buffer depth; power of 2, at least 2.
- `TIMEOUT`, 255: maximum cycles spent waiting in one handshake phase before abort; at least 1.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  host byte valid.
- `wr_data`  in  8  host byte.
- `wr_ready`  out  1  high when the FIFO is not full (`!full`); a push occurs when `wr_valid & wr_ready`.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `start_addr`  in  4  first CPU memory address.
- `len`  in  5  byte count; valid range 1..16.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  sticky error flag; cleared by an accepted `start` or by reset.
- `bus_load`  out  1  CPU load-mode enable.
- `bus_addr`  out  4  CPU memory address.
- `bus_data`  out  8  byte being written.
- `bus_stb`  out  1  write strobe.
- `bus_ack`  in  1  CPU acknowledge, synchronous to `clk`.

## Operation
- **Reset**: every output is 0 except `wr_ready`, which is 1. FIFO empty, state IDLE, counters 0.
- **FIFO**
  - Push and pop in the same cycle are both legal; occupancy is unchanged.
  - Pushes are accepted in any state.
  - A pop occurs only on the STB_HI→STB_LO transition.
  - Data order is strictly FIFO.
- **IDLE**
  - `start` with `len` in 1..16: latch `start_addr` and `len`, clear `err`, go to WAIT_DATA.
  - `start` with `len` of 0 or greater than 16: set `err`, stay in IDLE, no bus activity.
- **WAIT_DATA**: `busy=1`, `bus_load=1`. Go to SETUP when the FIFO is not empty.
- **SETUP** (1 cycle): `bus_addr` = current address, `bus_data` = FIFO head, `bus_stb=0`. Go to STB_HI.
- **STB_HI**
  - `bus_stb=1`; `bus_addr` and `bus_data` are held.
  - On `bus_ack=1`: pop the FIFO, increment the address (15 wraps to 0), decrement the remaining count, go to STB_LO.
- **STB_LO**: `bus_stb=0`. On `bus_ack=0`:
  - remaining count > 0: go to WAIT_DATA.
  - remaining count = 0: go to DONE.
- **DONE** (1 cycle): `done=1`, `busy=0`, `bus_load=0`. Go to IDLE.
- **Timeout**
  - The timeout counter clears on entry to STB_HI and on entry to STB_LO.
  - It increments each cycle the state is held.
  - On reaching TIMEOUT: go to IDLE, `err=1`, drop `bus_stb` and `bus_load`, flush the FIFO, `busy=0`, no `done`.
  - WAIT_DATA has no timeout; the host owns data supply.
- **Outside a transfer** (IDLE/DONE), `bus_addr` and `bus_data` are driven to 0.
- **Reset mid-transfer** returns to the reset state on the next edge. `bus_stb` and `bus_load` are 0 in that cycle.

## Timing
- All outputs are registered; `wr_ready` is derived from registered occupancy only.
- Accepted `start` at edge N: `busy` and `bus_load` are high from cycle N+1. If the FIFO is non-empty, SETUP occurs in cycle N+2.
- With `bus_ack` following `bus_stb` by 0 cycles, each byte takes 4 cycles: WAIT_DATA, SETUP, STB_HI, STB_LO.
- The final STB_LO is followed by the DONE cycle.
- `bus_data` and `bus_addr` are stable from SETUP through the end of STB_HI. Setup before `bus_stb` rises is at least 1 cycle.
- `bus_ack` is sampled only in STB_HI and STB_LO; its value in other states is ignored.

## Test plan
- **Basic load**: reset; push 0x3A, 0x5C, 0x01; `start` with `start_addr=2`, `len=3`; responder acks with 1-cycle latency.
  - Expect writes (2,0x3A), (3,0x5C), (4,0x01).
  - Expect exactly one `done` pulse, `err=0`, FIFO empty.
- **Wrap and starvation**: `start_addr=14`, `len=4`; push bytes one at a time with 10-cycle gaps.
  - Expect addresses 14, 15, 0, 1.
  - Expect WAIT_DATA stalls with `bus_stb=0` and `bus_load=1`, and no timeout.
- **Timeout**: TIMEOUT=8; the responder never raises ack.
  - Expect `bus_stb` high for 8 cycles, then `err=1`, `busy=0`, `bus_load=0`, FIFO flushed.
  - A following valid `start` clears `err`.
- **Invalid length**: `start` with `len=0`, then with `len=17`.
  - Expect `err=1` each time, `busy` stays 0, no bus activity.
- **Backpressure**: with FIFO_DEPTH=4 and no `start`, push 5 bytes.
  - Expect `wr_ready=0` after the 4th push; the 5th byte is accepted only after the first pop.
  - Check a simultaneous push and pop in the same cycle.
- **Reset mid-operation**: assert `rst` during STB_HI.
  - On the next cycle expect every output at its reset value and `wr_ready=1`.
